// File: rtl/cmp_db_strobe.sv
// cmp_db_strobe: receive-side tester pin channel. It strobes the DUT pin once per
// tester cycle and compares the strobed value against a double-buffered expected/mask
// pair, then accumulates pass/fail status.
// Ports:
//   clk_i, rst_ni               tester clock, asynchronous active-low reset
//   en_cmp_logic_i              runs the cycle counter and enables strobes
//   load_i, transfer_i          capture exp/mask into the buffer stage / move the buffer to the active stage
//   exp_i, mask_i               expected value and don't-care for the compare
//   dut_in_i                    DUT output pin, already synchronous to clk_i
//   strobe_1_i/cycle_length_1_i timing set 1; strobe_2_i/cycle_length_2_i timing set 2
//   test_cycle_i                selects the timing set (0 = set 1)
//   clr_fail_i                  clears fail_o and fail_count_o
//   cycle_start_o               high while the counter is 0 and enabled
//   sample_vld_o, sample_o      strobed value and its valid pulse
//   cycle_fail_o                pulse when the strobed value mismatches
//   fail_o, fail_count_o        sticky fail flag, saturating fail counter
//   strobe_err_o                sticky: latched strobe lies outside the cycle
module cmp_db_strobe #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_cmp_logic_i,
    input  logic             load_i,
    input  logic             transfer_i,
    input  logic             exp_i,
    input  logic             mask_i,
    input  logic             dut_in_i,
    input  logic [6:0]       strobe_1_i,
    input  logic [7:0]       cycle_length_1_i,
    input  logic [6:0]       strobe_2_i,
    input  logic [7:0]       cycle_length_2_i,
    input  logic             test_cycle_i,
    input  logic             clr_fail_i,
    output logic             cycle_start_o,
    output logic             sample_vld_o,
    output logic             sample_o,
    output logic             cycle_fail_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] fail_count_o,
    output logic             strobe_err_o
);
    logic             din_q, buf_exp_q, buf_mask_q, act_exp_q, act_mask_q;
    logic             stb_q, cmp_exp_q, cmp_mask_q, vld_q, smp_q, cf_q, fail_q, err_q;
    logic [7:0]       cnt_q, cnt_d, len_q, len_d;
    logic [6:0]       str_q, str_d;
    logic [CNT_W-1:0] fc_q, fc_d;
    logic             cyc0, stb, fail_d, err_d;

    // At count 0 the newly selected timing set is used directly, so the whole
    // cycle (including a strobe at count 0) runs on one consistent pair.
    always_comb begin
        cyc0   = en_cmp_logic_i && (cnt_q == 8'd0);
        str_d  = cyc0 ? (test_cycle_i ? strobe_2_i : strobe_1_i) : str_q;
        len_d  = cyc0 ? (test_cycle_i ? cycle_length_2_i : cycle_length_1_i) : len_q;
        stb    = en_cmp_logic_i && (cnt_q == {1'b0, str_d}) && ({1'b0, str_d} < len_d);
        cnt_d  = (!en_cmp_logic_i || len_d <= 8'd1 || cnt_q == len_d - 8'd1) ? 8'd0 : cnt_q + 8'd1;
        err_d  = err_q || (cyc0 && ({1'b0, str_d} >= len_d) && (len_d != 8'd0));
        fail_d = cf_q || (fail_q && !clr_fail_i);
        // A clear coinciding with a fail keeps that fail as the first count.
        fc_d   = clr_fail_i ? {{(CNT_W-1){1'b0}}, cf_q} :
                 (cf_q && fc_q != '1) ? fc_q + 1'b1 : fc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            din_q      <= 1'b0;
            buf_exp_q  <= 1'b0;
            buf_mask_q <= 1'b0;
            act_exp_q  <= 1'b0;
            act_mask_q <= 1'b0;
            cnt_q      <= 8'd0;
            str_q      <= 7'd0;
            len_q      <= 8'd0;
            stb_q      <= 1'b0;
            cmp_exp_q  <= 1'b0;
            cmp_mask_q <= 1'b0;
            vld_q      <= 1'b0;
            smp_q      <= 1'b0;
            cf_q       <= 1'b0;
            fail_q     <= 1'b0;
            fc_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            din_q <= dut_in_i;
            if (load_i) begin
                buf_exp_q  <= exp_i;
                buf_mask_q <= mask_i;
            end else if (transfer_i) begin
                act_exp_q  <= buf_exp_q;
                act_mask_q <= buf_mask_q;
            end
            cnt_q <= cnt_d;
            if (cyc0) begin
                str_q <= str_d;
                len_q <= len_d;
            end
            stb_q <= stb;
            // Snapshot the active pair at the strobe edge so a same-cycle transfer
            // only affects later compares.
            if (stb) begin
                cmp_exp_q  <= act_exp_q;
                cmp_mask_q <= act_mask_q;
            end
            vld_q <= stb_q && en_cmp_logic_i;
            cf_q  <= stb_q && en_cmp_logic_i && !cmp_mask_q && (din_q != cmp_exp_q);
            if (stb_q && en_cmp_logic_i) smp_q <= din_q;
            fail_q <= fail_d;
            fc_q   <= fc_d;
            err_q  <= err_d;
        end
    end

    assign cycle_start_o = cyc0 && rst_ni;
    assign sample_vld_o  = vld_q;
    assign sample_o      = smp_q;
    assign cycle_fail_o  = cf_q;
    assign fail_o        = fail_q;
    assign fail_count_o  = fc_q;
    assign strobe_err_o  = err_q;
endmodule

// File: tb/tb_cmp_db_strobe.sv
// tb_cmp_db_strobe: directed vector table plus hand-written sequences for cmp_db_strobe.
module tb_cmp_db_strobe;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0, rst_ni = 1'b0, en_cmp_logic_i = 1'b0, load_i = 1'b0;
    logic             transfer_i = 1'b0, exp_i = 1'b0, mask_i = 1'b0, dut_in_i = 1'b0;
    logic [6:0]       strobe_1_i = '0, strobe_2_i = '0;
    logic [7:0]       cycle_length_1_i = '0, cycle_length_2_i = '0;
    logic             test_cycle_i = 1'b0, clr_fail_i = 1'b0;
    logic             cycle_start_o, sample_vld_o, sample_o, cycle_fail_o, fail_o, strobe_err_o;
    logic [CNT_W-1:0] fail_count_o;

    cmp_db_strobe #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_cmp_logic_i(en_cmp_logic_i), .load_i(load_i),
        .transfer_i(transfer_i), .exp_i(exp_i), .mask_i(mask_i), .dut_in_i(dut_in_i),
        .strobe_1_i(strobe_1_i), .cycle_length_1_i(cycle_length_1_i),
        .strobe_2_i(strobe_2_i), .cycle_length_2_i(cycle_length_2_i),
        .test_cycle_i(test_cycle_i), .clr_fail_i(clr_fail_i),
        .cycle_start_o(cycle_start_o), .sample_vld_o(sample_vld_o), .sample_o(sample_o),
        .cycle_fail_o(cycle_fail_o), .fail_o(fail_o), .fail_count_o(fail_count_o),
        .strobe_err_o(strobe_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] len;
        logic [6:0] str;
        logic       e, m, d, smp;
        int         nfail;
    } vec_t;

    int checks = 0, failures = 0;
    int r_ncs, r_lcs, r_nvld, r_fvld, r_lvld, r_nfail, r_ffail;
    logic r_smp;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_xfer(input logic e, input logic m);
        en_cmp_logic_i = 1'b0;
        exp_i = e; mask_i = m; load_i = 1'b1;
        step;
        load_i = 1'b0; transfer_i = 1'b1;
        step;
        transfer_i = 1'b0;
    endtask

    // Runs n enabled clocks from count 0, recording pulse counts and positions,
    // then disables and lets the counter return to 0.
    task automatic run(input int n, input int xfer_at, input int tgl_at, input int clr_at);
        r_ncs = 0; r_lcs = -1; r_nvld = 0; r_fvld = -1; r_lvld = -1; r_nfail = 0; r_ffail = -1;
        r_smp = 1'bx;
        en_cmp_logic_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            transfer_i = (i == xfer_at);
            clr_fail_i = (i == clr_at);
            if (i == tgl_at) test_cycle_i = 1'b1;
            #1;
            if (cycle_start_o) begin r_ncs++; r_lcs = i; end
            if (sample_vld_o) begin
                r_nvld++; r_lvld = i; r_smp = sample_o;
                if (r_fvld < 0) r_fvld = i;
            end
            if (cycle_fail_o) begin
                r_nfail++;
                if (r_ffail < 0) r_ffail = i;
            end
            step;
        end
        transfer_i = 1'b0; clr_fail_i = 1'b0; en_cmp_logic_i = 1'b0;
        step;
    endtask

    initial begin
        vec_t v[7];
        int exp_fc;
        v[0] = '{8'd10, 7'd4, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        v[1] = '{8'd10, 7'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        v[2] = '{8'd10, 7'd4, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        v[3] = '{8'd5,  7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        v[4] = '{8'd6,  7'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
        v[5] = '{8'd8,  7'd5, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        v[6] = '{8'd3,  7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        exp_fc = 0;

        // Reset state, with enable high so cycle_start must be held low by reset.
        en_cmp_logic_i = 1'b1;
        step; step;
        check("rst_cycle_start", cycle_start_o, 0);
        check("rst_sample_vld", sample_vld_o, 0);
        check("rst_sample", sample_o, 0);
        check("rst_cycle_fail", cycle_fail_o, 0);
        check("rst_fail", fail_o, 0);
        check("rst_fail_count", fail_count_o, 0);
        check("rst_strobe_err", strobe_err_o, 0);
        en_cmp_logic_i = 1'b0;
        rst_ni = 1'b1;
        step;

        // Table: three full cycles per vector on timing set 1.
        for (int k = 0; k < 7; k++) begin
            strobe_1_i = v[k].str; cycle_length_1_i = v[k].len; test_cycle_i = 1'b0;
            dut_in_i = v[k].d;
            load_xfer(v[k].e, v[k].m);
            run(3 * int'(v[k].len), -1, -1, -1);
            exp_fc = (exp_fc + v[k].nfail > 15) ? 15 : exp_fc + v[k].nfail;
            check($sformatf("v%0d_ncs", k), r_ncs, 3);
            check($sformatf("v%0d_nvld", k), r_nvld, 3);
            check($sformatf("v%0d_first_vld", k), r_fvld, int'(v[k].str) + 2);
            check($sformatf("v%0d_sample", k), r_smp, v[k].smp);
            check($sformatf("v%0d_nfail", k), r_nfail, v[k].nfail);
            check($sformatf("v%0d_fail_count", k), fail_count_o, exp_fc);
        end
        check("tbl_fail", fail_o, 1);

        // LOAD and TRANSFER together: load wins, active stage keeps exp=1.
        strobe_1_i = 7'd4; cycle_length_1_i = 8'd10; dut_in_i = 1'b1;
        load_xfer(1'b1, 1'b0);
        exp_i = 1'b0; load_i = 1'b1; transfer_i = 1'b1;
        step;
        load_i = 1'b0; transfer_i = 1'b0;
        run(20, -1, -1, -1);
        check("t3_both_nfail", r_nfail, 0);
        transfer_i = 1'b1;
        step;
        transfer_i = 1'b0;
        run(20, -1, -1, -1);
        check("t3_xfer_nfail", r_nfail, 2);
        // Transfer in the strobe clock: first compare keeps exp=0, second sees exp=1.
        exp_i = 1'b1; mask_i = 1'b0; load_i = 1'b1;
        step;
        load_i = 1'b0; dut_in_i = 1'b0;
        run(20, 4, -1, -1);
        check("t3_stb_xfer_nfail", r_nfail, 1);
        check("t3_stb_xfer_first", r_ffail, 16);
        check("t3_fail_count", fail_count_o, 12);

        // Mid-cycle timing set change applies to the next cycle.
        strobe_2_i = 7'd2; cycle_length_2_i = 8'd5; dut_in_i = 1'b1; test_cycle_i = 1'b0;
        run(20, -1, 3, -1);
        check("t4_ncs", r_ncs, 3);
        check("t4_last_cs", r_lcs, 15);
        check("t4_nvld", r_nvld, 3);
        check("t4_first_vld", r_fvld, 6);
        check("t4_last_vld", r_lvld, 19);
        check("t4_err_clear", strobe_err_o, 0);
        strobe_2_i = 7'd7;
        run(10, -1, -1, -1);
        check("t4_err_ncs", r_ncs, 2);
        check("t4_err_nvld", r_nvld, 0);
        check("t4_err_set", strobe_err_o, 1);

        // Saturation and clear.
        clr_fail_i = 1'b1;
        step;
        clr_fail_i = 1'b0;
        check("t5_clr_count", fail_count_o, 0);
        check("t5_clr_fail", fail_o, 0);
        test_cycle_i = 1'b0; strobe_1_i = 7'd0; cycle_length_1_i = 8'd3; dut_in_i = 1'b0;
        load_xfer(1'b1, 1'b0);
        run(60, -1, -1, -1);
        check("t5_nfail", r_nfail, 20);
        check("t5_sat_count", fail_count_o, 15);
        check("t5_sat_fail", fail_o, 1);
        run(3, -1, -1, 2);
        check("t5_coinc_nfail", r_nfail, 1);
        check("t5_coinc_count", fail_count_o, 1);
        check("t5_coinc_fail", fail_o, 1);

        // Reset in the middle of a cycle.
        strobe_1_i = 7'd4; cycle_length_1_i = 8'd10; dut_in_i = 1'b1;
        en_cmp_logic_i = 1'b1;
        step; step; step;
        check("t6_err_before", strobe_err_o, 1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_cycle_start", cycle_start_o, 0);
        check("t6_rst_fail_count", fail_count_o, 0);
        check("t6_rst_fail", fail_o, 0);
        check("t6_rst_err", strobe_err_o, 0);
        check("t6_rst_vld", sample_vld_o, 0);
        step;
        rst_ni = 1'b1;
        #1;
        check("t6_first_cs", cycle_start_o, 1);
        run(6, -1, -1, -1);
        check("t6_ncs", r_ncs, 1);
        check("t6_nvld", r_nvld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
